// File: rtl/ble_packet_parser_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ble_pkg
// Description : Shared constants, frame-type and parser-state enums, and
//               helper functions for the BLE command packet parser.
// Revision    : 1.0 - initial release
// ============================================================================
package ble_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // Largest payload of any frame type; sizes the shadow buffer.
  localparam int MAX_PAYLOAD = 6;

  // Number of 9-bit clamped fields on the commit path.
  localparam int NUM_FIELDS = 8;

  typedef enum logic [7:0] {
    TYPE_SETPT = 8'h01,
    TYPE_PGAIN = 8'h02,
    TYPE_YGAIN = 8'h03,
    TYPE_CTRL  = 8'h04
  } frame_type_t;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    TYPE    = 2'd1,
    PAYLOAD = 2'd2,
    CHECK   = 2'd3
  } parser_state_t;

  // Payload length in bytes for a type byte; 0 marks an unknown type.
  function automatic logic [2:0] payload_len(input logic [7:0] type_byte);
    logic [2:0] len;
    len = 3'd0;
    case (type_byte)
      TYPE_SETPT: len = 3'd4;
      TYPE_PGAIN: len = 3'd6;
      TYPE_YGAIN: len = 3'd6;
      TYPE_CTRL:  len = 3'd2;
      default:    len = 3'd0;
    endcase
    return len;
  endfunction

  // Which big-endian 16-bit payload word feeds each 9-bit field.
  // Field order: set_pitch, set_yaw, pitch kP/kI/kD, yaw kP/kI/kD.
  function automatic int field_word(input int field);
    int w;
    case (field)
      0:       w = 0;
      1:       w = 1;
      2:       w = 0;
      3:       w = 1;
      4:       w = 2;
      5:       w = 0;
      6:       w = 1;
      7:       w = 2;
      default: w = 0;
    endcase
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ble_packet_parser_sat_s16_to_s9.sv
`default_nettype none
// ============================================================================
// Module      : sat_s16_to_s9
// Description : Combinational clamp of a signed 16-bit value into the
//               signed 9-bit range [-256, 255].
// Revision    : 1.0 - initial release
// ============================================================================
module sat_s16_to_s9 (
  input  logic signed [15:0] in_value,
  output logic signed [8:0]  out_value
);

  // Clamp to the representable range, otherwise keep the low 9 bits.
  always_comb begin
    out_value = in_value[8:0];
    if (in_value > 16'sd255) begin
      out_value = 9'sd255;
    end else if (in_value < -16'sd256) begin
      out_value = -9'sd256;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ble_packet_parser.sv
`default_nettype none
// ============================================================================
// Module      : ble_packet_parser
// Description : Frames the BLE UART byte stream into typed, XOR-checksummed
//               packets and atomically commits decoded setpoints, PID gains
//               and control bytes when a packet checks out.
// Revision    : 1.0 - initial release
// ============================================================================
module ble_packet_parser
  import ble_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic signed [8:0] set_pitch,
  output logic signed [8:0] set_yaw,
  output logic signed [8:0] pitch_kP,
  output logic signed [8:0] pitch_kI,
  output logic signed [8:0] pitch_kD,
  output logic signed [8:0] yaw_kP,
  output logic signed [8:0] yaw_kI,
  output logic signed [8:0] yaw_kD,
  output logic [7:0]        initialize_mpu,
  output logic [7:0]        initialize_motor,
  output logic              vector_valid,
  output logic              frame_error,
  output logic [7:0]        err_count
);

  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  // Idle count seen on the clock that completes TIMEOUT_CYCLES idle clocks.
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

  parser_state_t     state;
  parser_state_t     next_state;
  frame_type_t       frame_type;
  logic [2:0]        byte_cnt;
  logic [7:0]        chk_acc;
  logic [IDLE_W-1:0] idle_cnt;
  logic [7:0]        shadow [MAX_PAYLOAD];

  logic              commit;
  logic              err_evt;
  logic [2:0]        wr_idx;

  logic signed [15:0] words   [MAX_PAYLOAD/2];
  logic signed [8:0]  sat_val [NUM_FIELDS];

  // Payload bytes fill the shadow buffer from index 0 upward.
  assign wr_idx = payload_len(frame_type) - byte_cnt;

  // Reassemble big-endian 16-bit words from the shadow buffer.
  generate
    for (genvar k = 0; k < MAX_PAYLOAD/2; k++) begin : g_word
      assign words[k] = {shadow[2*k], shadow[2*k+1]};
    end
  endgenerate

  // One clamp per 9-bit output field, fed by that field's payload word.
  generate
    for (genvar f = 0; f < NUM_FIELDS; f++) begin : g_sat
      localparam int WORD = field_word(f);
      sat_s16_to_s9 u_sat (
        .in_value  (words[WORD]),
        .out_value (sat_val[f])
      );
    end
  endgenerate

  // Parser state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= HUNT;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode, commit and error events; a strobe always beats timeout.
  always_comb begin
    next_state = state;
    commit     = 1'b0;
    err_evt    = 1'b0;
    if (rx_valid) begin
      case (state)
        HUNT: begin
          if (rx_data == SYNC_BYTE) begin
            next_state = TYPE;
          end
        end
        TYPE: begin
          if (payload_len(rx_data) != 3'd0) begin
            next_state = PAYLOAD;
          end else begin
            next_state = HUNT;
            err_evt    = 1'b1;
          end
        end
        PAYLOAD: begin
          if (byte_cnt == 3'd1) begin
            next_state = CHECK;
          end
        end
        CHECK: begin
          next_state = HUNT;
          if (rx_data == chk_acc) begin
            commit = 1'b1;
          end else begin
            err_evt = 1'b1;
          end
        end
        default: next_state = HUNT;
      endcase
    end else if (state != HUNT && idle_cnt == IDLE_LAST) begin
      next_state = HUNT;
      err_evt    = 1'b1;
    end
  end

  // Frame datapath: type latch, byte counter, running XOR, shadow buffer, idle timer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      frame_type <= TYPE_SETPT;
      byte_cnt   <= 3'd0;
      chk_acc    <= 8'h00;
      idle_cnt   <= '0;
      for (int i = 0; i < MAX_PAYLOAD; i++) begin
        shadow[i] <= 8'h00;
      end
    end else begin
      if (rx_valid || next_state == HUNT) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + IDLE_W'(1);
      end

      if (rx_valid) begin
        case (state)
          TYPE: begin
            if (payload_len(rx_data) != 3'd0) begin
              frame_type <= frame_type_t'(rx_data);
              byte_cnt   <= payload_len(rx_data);
              chk_acc    <= rx_data;
            end
          end
          PAYLOAD: begin
            shadow[wr_idx] <= rx_data;
            chk_acc        <= chk_acc ^ rx_data;
            byte_cnt       <= byte_cnt - 3'd1;
          end
          default: ;
        endcase
      end
    end
  end

  // Output registers: written only from the shadow buffer on a good checksum.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      set_pitch        <= '0;
      set_yaw          <= '0;
      pitch_kP         <= '0;
      pitch_kI         <= '0;
      pitch_kD         <= '0;
      yaw_kP           <= '0;
      yaw_kI           <= '0;
      yaw_kD           <= '0;
      initialize_mpu   <= 8'h00;
      initialize_motor <= 8'h00;
    end else if (commit) begin
      case (frame_type)
        TYPE_SETPT: begin
          set_pitch <= sat_val[0];
          set_yaw   <= sat_val[1];
        end
        TYPE_PGAIN: begin
          pitch_kP <= sat_val[2];
          pitch_kI <= sat_val[3];
          pitch_kD <= sat_val[4];
        end
        TYPE_YGAIN: begin
          yaw_kP <= sat_val[5];
          yaw_kI <= sat_val[6];
          yaw_kD <= sat_val[7];
        end
        TYPE_CTRL: begin
          initialize_mpu   <= shadow[0];
          initialize_motor <= shadow[1];
        end
        default: ;
      endcase
    end
  end

  // Status pulses and the saturating dropped-frame counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vector_valid <= 1'b0;
      frame_error  <= 1'b0;
      err_count    <= 8'h00;
    end else begin
      vector_valid <= commit;
      frame_error  <= err_evt;
      if (err_evt && err_count != 8'hFF) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ble_packet_parser.sv
`default_nettype none
// ============================================================================
// Module      : tb_ble_packet_parser
// Description : Self-checking bench for ble_packet_parser: directed frames
//               plus randomized streams compared every cycle against a
//               byte-queue reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ble_packet_parser;

  localparam int TO = 100;

  logic              clock;
  logic              reset_n;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic signed [8:0] set_pitch, set_yaw;
  logic signed [8:0] pitch_kP, pitch_kI, pitch_kD;
  logic signed [8:0] yaw_kP, yaw_kI, yaw_kD;
  logic [7:0]        initialize_mpu, initialize_motor;
  logic              vector_valid, frame_error;
  logic [7:0]        err_count;

  ble_packet_parser #(.TIMEOUT_CYCLES(TO)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .rx_data          (rx_data),
    .rx_valid         (rx_valid),
    .set_pitch        (set_pitch),
    .set_yaw          (set_yaw),
    .pitch_kP         (pitch_kP),
    .pitch_kI         (pitch_kI),
    .pitch_kD         (pitch_kD),
    .yaw_kP           (yaw_kP),
    .yaw_kI           (yaw_kI),
    .yaw_kD           (yaw_kD),
    .initialize_mpu   (initialize_mpu),
    .initialize_motor (initialize_motor),
    .vector_valid     (vector_valid),
    .frame_error      (frame_error),
    .err_count        (err_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: bytes of the current frame (type onward) in a queue.
  bit                m_in_frame;
  logic [7:0]        q [$];
  int                m_idle;
  logic signed [8:0] m_f [8];
  logic [7:0]        m_mpu, m_motor, m_err;
  bit                m_vv, m_fe;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int len_of(input logic [7:0] t);
    case (t)
      8'h01:   return 4;
      8'h02:   return 6;
      8'h03:   return 6;
      8'h04:   return 2;
      default: return 0;
    endcase
  endfunction

  function automatic logic signed [8:0] sat9(input logic signed [15:0] v);
    if (v > 255)  return 9'sd255;
    if (v < -256) return -9'sd256;
    return v[8:0];
  endfunction

  task automatic model_reset();
    m_in_frame = 0;
    q.delete();
    m_idle = 0;
    for (int i = 0; i < 8; i++) m_f[i] = '0;
    m_mpu = 8'h00; m_motor = 8'h00; m_err = 8'h00;
    m_vv = 0; m_fe = 0;
  endtask

  task automatic model_error();
    m_fe = 1;
    if (m_err != 8'hFF) m_err = m_err + 8'd1;
  endtask

  task automatic model_commit();
    m_vv = 1;
    case (q[0])
      8'h01: begin
        m_f[0] = sat9({q[1], q[2]});
        m_f[1] = sat9({q[3], q[4]});
      end
      8'h02: begin
        m_f[2] = sat9({q[1], q[2]});
        m_f[3] = sat9({q[3], q[4]});
        m_f[4] = sat9({q[5], q[6]});
      end
      8'h03: begin
        m_f[5] = sat9({q[1], q[2]});
        m_f[6] = sat9({q[3], q[4]});
        m_f[7] = sat9({q[5], q[6]});
      end
      default: begin
        m_mpu   = q[1];
        m_motor = q[2];
      end
    endcase
  endtask

  // One clock of the stream as seen by the model.
  task automatic model_step(input bit v, input logic [7:0] d);
    logic [7:0] x;
    m_vv = 0;
    m_fe = 0;
    if (v) begin
      m_idle = 0;
      if (!m_in_frame) begin
        if (d == 8'hA5) begin
          m_in_frame = 1;
          q.delete();
        end
      end else begin
        q.push_back(d);
        if (q.size() == 1) begin
          if (len_of(d) == 0) begin
            model_error();
            m_in_frame = 0;
          end
        end else if (q.size() == len_of(q[0]) + 2) begin
          x = 8'h00;
          for (int i = 0; i < q.size() - 1; i++) x = x ^ q[i];
          if (x == d) model_commit();
          else model_error();
          m_in_frame = 0;
        end
      end
    end else if (m_in_frame) begin
      m_idle++;
      if (m_idle == TO) begin
        model_error();
        m_in_frame = 0;
      end
    end
  endtask

  task automatic check_all();
    check("set_pitch",        32'(set_pitch),        32'(m_f[0]));
    check("set_yaw",          32'(set_yaw),          32'(m_f[1]));
    check("pitch_kP",         32'(pitch_kP),         32'(m_f[2]));
    check("pitch_kI",         32'(pitch_kI),         32'(m_f[3]));
    check("pitch_kD",         32'(pitch_kD),         32'(m_f[4]));
    check("yaw_kP",           32'(yaw_kP),           32'(m_f[5]));
    check("yaw_kI",           32'(yaw_kI),           32'(m_f[6]));
    check("yaw_kD",           32'(yaw_kD),           32'(m_f[7]));
    check("initialize_mpu",   32'(initialize_mpu),   32'(m_mpu));
    check("initialize_motor", 32'(initialize_motor), 32'(m_motor));
    check("vector_valid",     32'(vector_valid),     32'(m_vv));
    check("frame_error",      32'(frame_error),      32'(m_fe));
    check("err_count",        32'(err_count),        32'(m_err));
  endtask

  // Drive one clock of input, then check outputs just after the edge.
  task automatic cyc(input bit v, input logic [7:0] d);
    rx_valid = v;
    rx_data  = v ? d : 8'($urandom);
    @(posedge clock);
    #1;
    model_step(v, d);
    check_all();
  endtask

  task automatic tx(input logic [7:0] b);
    cyc(1'b1, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00);
  endtask

  task automatic send(input logic [7:0] bytes [$]);
    foreach (bytes[i]) tx(bytes[i]);
  endtask

  // Asynchronous reset held for two clocks; outputs must read zero throughout.
  task automatic do_reset();
    rx_valid = 1'b0;
    reset_n  = 1'b0;
    model_reset();
    #1;
    check_all();
    for (int i = 0; i < 2; i++) begin
      @(posedge clock);
      #1;
      check_all();
    end
    reset_n = 1'b1;
  endtask

  task automatic random_frame();
    logic [7:0] fr [$];
    logic [7:0] t, x;
    int         n, r, gap;
    if ($urandom_range(0, 7) == 0) begin
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) fr.push_back(8'($urandom));
    end
    fr.push_back(8'hA5);
    t = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(1, 4));
    fr.push_back(t);
    x = t;
    for (int i = 0; i < len_of(t); i++) begin
      r = $urandom_range(0, 7);
      if (r == 0)      fr.push_back(8'hA5);
      else if (r == 1) fr.push_back(8'h00);
      else if (r == 2) fr.push_back(8'hFF);
      else             fr.push_back(8'($urandom));
      x = x ^ fr[fr.size()-1];
    end
    if (len_of(t) != 0) begin
      if ($urandom_range(0, 5) == 0) x = x ^ 8'(1 << $urandom_range(0, 7));
      fr.push_back(x);
    end
    foreach (fr[i]) begin
      r = $urandom_range(0, 19);
      if (r == 0)       gap = $urandom_range(TO - 5, TO + 5);
      else if (r < 12)  gap = 0;
      else              gap = $urandom_range(1, 3);
      idle(gap);
      tx(fr[i]);
    end
  endtask

  initial begin
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    reset_n  = 1'b0;
    model_reset();
    @(posedge clock);
    #1;
    do_reset();

    // Setpoint frame.
    send('{8'hA5, 8'h01, 8'h00, 8'h64, 8'hFF, 8'h38, 8'hA2});
    check("dir_set_pitch", 32'(set_pitch), 32'(100));
    check("dir_set_yaw",   32'(set_yaw),   32'(-200));
    check("dir_setpt_vv",  32'(vector_valid), 32'(1));
    check("dir_setpt_kp",  32'(pitch_kP),  32'(0));
    idle(2);

    // Saturating pitch gains.
    send('{8'hA5, 8'h02, 8'h01, 8'h90, 8'hFE, 8'h00, 8'h00, 8'h05, 8'h68});
    check("dir_pitch_kP", 32'(pitch_kP), 32'(255));
    check("dir_pitch_kI", 32'(pitch_kI), 32'(-256));
    check("dir_pitch_kD", 32'(pitch_kD), 32'(5));
    idle(2);

    // Bad checksum.
    do_reset();
    send('{8'hA5, 8'h04, 8'h01, 8'h01, 8'h00});
    check("dir_badchk_fe",  32'(frame_error), 32'(1));
    check("dir_badchk_cnt", 32'(err_count),   32'(1));
    check("dir_badchk_mpu", 32'(initialize_mpu), 32'(0));
    idle(2);

    // Garbage then a control frame.
    do_reset();
    send('{8'h00, 8'h13, 8'hA5, 8'h04, 8'h01, 8'h01, 8'h04});
    check("dir_garbage_mpu",   32'(initialize_mpu),   32'(1));
    check("dir_garbage_motor", 32'(initialize_motor), 32'(1));
    check("dir_garbage_cnt",   32'(err_count),        32'(0));
    idle(2);

    // Mid-frame timeout, then a normal control frame.
    do_reset();
    send('{8'hA5, 8'h01, 8'h00});
    idle(TO);
    check("dir_timeout_cnt", 32'(err_count), 32'(1));
    send('{8'hA5, 8'h04, 8'h00, 8'h01, 8'h05});
    check("dir_timeout_motor", 32'(initialize_motor), 32'(1));
    idle(2);

    // Reset mid-frame, then a yaw gain frame.
    send('{8'hA5, 8'h03, 8'h00});
    do_reset();
    send('{8'hA5, 8'h03, 8'h00, 8'h10, 8'hFF, 8'hF0, 8'h00, 8'h20, 8'h3C});
    check("dir_yaw_kP", 32'(yaw_kP), 32'(16));
    check("dir_yaw_kI", 32'(yaw_kI), 32'(-16));
    check("dir_yaw_kD", 32'(yaw_kD), 32'(32));
    idle(2);

    // Randomized streams.
    for (int i = 0; i < 300; i++) random_frame();
    idle(TO + 2);

    // Error counter saturation via unknown types.
    do_reset();
    for (int i = 0; i < 260; i++) send('{8'hA5, 8'h00});
    check("dir_errcnt_sat", 32'(err_count), 32'(255));
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/ble_packet_parser.md
# ble_packet_parser

Byte-level command parser between the BLE UART receiver and the motion/control logic. It consumes the received byte stream and frames it into typed, checksummed packets. Decoded setpoints, PID gains and enable bytes are held in output registers that only update atomically when a packet passes its checksum. Downstream consumers are the setpoint-to-motor mapping and the control loop; `vector_valid` tells them a fresh value set has landed.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1_000_000: maximum idle clocks between bytes inside a frame (10 ms at 100 MHz).

Ports:
- clock  in  1  system clock, 100 MHz
- reset_n  in  1  reset, asynchronous, active-low
- rx_data  in  8  received byte, valid only when rx_valid=1
- rx_valid  in  1  one-cycle strobe per received byte
- set_pitch, set_yaw  out  9 signed  commanded pitch/yaw setpoints
- pitch_kP, pitch_kI, pitch_kD  out  9 signed  pitch PID gains
- yaw_kP, yaw_kI, yaw_kD  out  9 signed  yaw PID gains
- initialize_mpu, initialize_motor  out  8  enable/control bytes, bit 0 is the primary enable
- vector_valid  out  1  one-cycle pulse when outputs were just updated
- frame_error  out  1  one-cycle pulse on any dropped frame
- err_count  out  8  saturating count of dropped frames

## Operation
- Frame format: SYNC (0xA5), TYPE, payload, CHK. CHK is the XOR of TYPE and all payload bytes. Multi-byte fields are 16-bit big-endian signed.
- Frame types and payload lengths:
  - 0x01: 4 bytes, set_pitch then set_yaw.
  - 0x02: 6 bytes, pitch kP, kI, kD.
  - 0x03: 6 bytes, yaw kP, kI, kD.
  - 0x04: 2 bytes, initialize_mpu then initialize_motor.
- Payload bytes go into a 6-byte shadow buffer. The output registers are never written directly from the stream.
- State machine:
  - HUNT: any byte other than 0xA5 is ignored with no error. 0xA5 goes to TYPE.
  - TYPE: a valid type latches the type, loads the byte counter with the payload length, seeds the running XOR with TYPE, and goes to PAYLOAD. An unknown type goes to HUNT with an error.
  - PAYLOAD: each byte is stored and XORed in, and the counter decrements. The last byte goes to CHECK.
  - CHECK: on a match, only the fields of the latched type are committed and the FSM goes to HUNT. On a mismatch, nothing is committed, the FSM goes to HUNT, and an error is raised.
- A 0xA5 byte inside TYPE, PAYLOAD or CHECK is treated as data. There is no escaping or resync mid-frame.
- Saturation on commit: each 16-bit value is clamped to the 9-bit signed range. Values above 255 become 255, values below -256 become -256, and all others take the low 9 bits.
- Bytes for types 0x04 are committed unmodified, with no saturation.
- Error event: frame_error pulses and err_count increments. err_count holds at 255.
- Timeout: an idle counter clears on every rx_valid. In any state other than HUNT, reaching TIMEOUT_CYCLES idle clocks forces HUNT and raises an error. The counter does not run in HUNT.

## Timing
- Reset values: FSM in HUNT, all 9-bit outputs 0, initialize_mpu and initialize_motor 0x00, vector_valid 0, frame_error 0, err_count 0. The shadow buffer, XOR and counters also clear.
- Commit latency: the CHK byte is strobed in cycle N. The output registers change and vector_valid=1 in cycle N+1, for exactly one cycle.
- Error pulses: frame_error for a bad CHK or unknown TYPE is high in the cycle after the offending strobe. A timeout error is high in the cycle after expiry.
- Back-to-back strobes every cycle are legal. A new SYNC may arrive in the cycle after CHK.
- If rx_valid coincides with timeout expiry, the byte wins: the timeout is cancelled and the byte is processed normally.
- Reset asserted mid-frame: the partial frame is discarded immediately and all outputs return to their reset values.

## Structure
- Shared package ble_pkg holds:
  - SYNC_BYTE = 8'hA5.
  - The frame-type enum, with TYPE_SETPT=1, TYPE_PGAIN=2, TYPE_YGAIN=3, TYPE_CTRL=4.
  - A payload-length function of the type.
  - The parser state enum: HUNT, TYPE, PAYLOAD, CHECK.
- One sub-module: sat_s16_to_s9, a combinational clamp. It is instanced once per 9-bit field on the commit path.

## Test plan
- Setpoint frame: send A5 01 00 64 FF 38 with CHK=0x01^0x00^0x64^0xFF^0x38=0xA2.
  - Cycle after CHK: set_pitch=100, set_yaw=-200, vector_valid=1 for one cycle.
  - Gains are unchanged.
- Saturation: send a type-0x02 frame with 16-bit values 0x0190, 0xFE00 and 0x0005, plus a correct CHK.
  - Expected: pitch_kP=255, pitch_kI=-256, pitch_kD=5.
- Bad checksum: send A5 04 01 01 00. The correct CHK is 0x04.
  - Expected: initialize_mpu and initialize_motor stay 0x00, frame_error pulses, err_count=1, and vector_valid stays 0.
- Garbage then frame: send 00 13 A5 04 01 01 04.
  - Expected: the garbage bytes raise no error. initialize_mpu=0x01, initialize_motor=0x01, vector_valid pulses once.
- Timeout: use TIMEOUT_CYCLES=100. Send A5 01 00, then idle for 100 cycles, then send a complete valid type-0x04 frame.
  - Expected: err_count=1 after the idle period, and the type-0x04 frame commits normally.
- Reset mid-frame: send A5 03 00, assert reset_n=0 for 2 cycles, then send a valid type-0x03 frame.
  - Expected: all outputs are 0 during reset, and the type-0x03 frame commits correctly.
